// File: rtl/pc_src_defs.sv
// -----------------------------------------------------------------------------
// pc_src_defs
// Shared definitions for the fetch-stage PC redirect control:
//   - pc_sel_e : select codes driven onto the PC source mux
//   - state_e  : redirect controller state encoding
//   - CNT_W    : width of the accepted-redirect counter
// -----------------------------------------------------------------------------
package pc_src_defs;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Codes 6 and 7 of the 3-bit mux select are deliberately left undefined.
  typedef enum logic [2:0] {
    SEL_PC4  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JAL  = 3'd2,
    SEL_JALR = 3'd3,
    SEL_TRAP = 3'd4,
    SEL_PEND = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/redirect_prio_enc.sv
// -----------------------------------------------------------------------------
// redirect_prio_enc
// Combinational priority encoder for the PC redirect requests.
// Priority: trap > jalr > branch_taken > jal > halt_req.
// Ports:
//   trap, jalr, branch_taken, jal, halt_req : request levels
//   redir_valid : a redirect (trap/jalr/branch/jal) wins this cycle
//   redir_sel   : mux code of the winning redirect (SEL_PC4 when none)
//   flush_mask  : [0] flush IF/ID, [1] flush ID/EX for the winner
//   halt_win    : halt_req wins (no redirect present)
// -----------------------------------------------------------------------------
module redirect_prio_enc
  import pc_src_defs::*;
(
  input  logic       trap,
  input  logic       jalr,
  input  logic       branch_taken,
  input  logic       jal,
  input  logic       halt_req,
  output logic       redir_valid,
  output pc_sel_e    redir_sel,
  output logic [1:0] flush_mask,
  output logic       halt_win
);

  always_comb begin
    redir_valid = 1'b0;
    redir_sel   = SEL_PC4;
    flush_mask  = 2'b00;
    halt_win    = 1'b0;
    if (trap) begin
      redir_valid = 1'b1;
      redir_sel   = SEL_TRAP;
      flush_mask  = 2'b11;
    end else if (jalr) begin
      redir_valid = 1'b1;
      redir_sel   = SEL_JALR;
      flush_mask  = 2'b11;
    end else if (branch_taken) begin
      redir_valid = 1'b1;
      redir_sel   = SEL_BR;
      flush_mask  = 2'b11;
    end else if (jal) begin
      // JAL resolves in ID, so only the instruction behind it in IF/ID is wrong-path.
      redir_valid = 1'b1;
      redir_sel   = SEL_JAL;
      flush_mask  = 2'b01;
    end else if (halt_req) begin
      halt_win = 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
// Drives the fetch PC source mux select, PC load enable and pipeline flushes.
// A redirect that arrives while fetch is stalled is captured into pend_target
// and replayed through mux input 5 on the first unstalled cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stall               : IF stall, PC must hold
//   branch_taken/_target, jal/_target, jalr/_target, trap/trap_vector,
//   halt_req            : redirect and halt requests
//   pc_src_sel          : mux select (0 PC+4 .. 5 pending target)
//   pend_target         : latched redirect target (mux input 5)
//   pc_write            : PC register load enable
//   flush_if_id/id_ex   : one-cycle pipeline flushes
//   halted              : controller is in HALT
//   redirect_count      : saturating count of accepted redirects
//   dbg_state           : current FSM state
//   dbg_pend_kind       : select code of the captured pending redirect
//
// Request/accept semantics: requests are levels sampled every cycle with no
// handshake back to the requester. A redirect counts as accepted in exactly the
// cycle its flushes are raised; losing or ignored requests are simply dropped
// because they belong to the wrong path.
// -----------------------------------------------------------------------------
module pc_redirect_ctrl
  import pc_src_defs::*;
#(
  parameter int bit_with = 32
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [bit_with-1:0] branch_target,
  input  logic                jal,
  input  logic [bit_with-1:0] jal_target,
  input  logic                jalr,
  input  logic [bit_with-1:0] jalr_target,
  input  logic                trap,
  input  logic [bit_with-1:0] trap_vector,
  input  logic                halt_req,
  output logic [2:0]          pc_src_sel,
  output logic [bit_with-1:0] pend_target,
  output logic                pc_write,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                halted,
  output logic [CNT_W-1:0]    redirect_count,
  output state_e              dbg_state,
  output pc_sel_e             dbg_pend_kind
);

  state_e              state_q, state_d;
  logic [bit_with-1:0] pend_target_q, pend_target_d;
  pc_sel_e             pend_kind_q, pend_kind_d;
  logic [CNT_W-1:0]    redirect_count_q, redirect_count_d;
  logic                cnt_inc;

  logic                redir_valid;
  pc_sel_e             redir_sel;
  logic [1:0]          flush_mask;
  logic                halt_win;
  logic [bit_with-1:0] win_target;

  pc_sel_e             sel_c;
  logic                pc_write_c;
  logic                flush_if_id_c;
  logic                flush_id_ex_c;

  redirect_prio_enc u_prio (
    .trap         (trap),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .jal          (jal),
    .halt_req     (halt_req),
    .redir_valid  (redir_valid),
    .redir_sel    (redir_sel),
    .flush_mask   (flush_mask),
    .halt_win     (halt_win)
  );

  always_comb begin
    win_target = '0;
    unique case (redir_sel)
      SEL_BR:   win_target = branch_target;
      SEL_JAL:  win_target = jal_target;
      SEL_JALR: win_target = jalr_target;
      SEL_TRAP: win_target = trap_vector;
      default:  win_target = '0;
    endcase
  end

  // State register, pending target and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RUN;
      pend_target_q    <= '0;
      pend_kind_q      <= SEL_PC4;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pend_target_q    <= pend_target_d;
      pend_kind_q      <= pend_kind_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pend_kind_d   = pend_kind_q;
    cnt_inc       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (halt_win) begin
          state_d = ST_HALT;
        end else if (redir_valid) begin
          cnt_inc = 1'b1;
          if (stall) begin
            state_d       = ST_PEND;
            pend_target_d = win_target;
            pend_kind_d   = redir_sel;
          end
        end
      end
      ST_PEND: begin
        // Only a trap can preempt a pending redirect; it is the oldest event.
        if (trap) begin
          cnt_inc = 1'b1;
          if (stall) begin
            pend_target_d = trap_vector;
            pend_kind_d   = SEL_TRAP;
          end
        end
        if (!stall) state_d = ST_RUN;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    redirect_count_d = (cnt_inc && (redirect_count_q != CNT_MAX))
                       ? redirect_count_q + CNT_W'(1) : redirect_count_q;
  end

  // Output logic: same-cycle path from requests to the PC mux. Gated by rst so
  // every output reads zero while reset is held.
  always_comb begin
    sel_c         = SEL_PC4;
    pc_write_c    = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_win) begin
            pc_write_c = 1'b0;
          end else if (redir_valid) begin
            flush_if_id_c = flush_mask[0];
            flush_id_ex_c = flush_mask[1];
            if (!stall) begin
              sel_c      = redir_sel;
              pc_write_c = 1'b1;
            end
          end else begin
            pc_write_c = ~stall;
          end
        end
        ST_PEND: begin
          if (trap) begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
          end
          if (!stall) begin
            sel_c      = trap ? SEL_TRAP : SEL_PEND;
            pc_write_c = 1'b1;
          end
        end
        default: begin
          sel_c = SEL_PC4;
        end
      endcase
    end
  end

  assign pc_src_sel     = sel_c;
  assign pc_write       = pc_write_c;
  assign flush_if_id    = flush_if_id_c;
  assign flush_id_ex    = flush_id_ex_c;
  assign pend_target    = pend_target_q;
  assign halted         = (state_q == ST_HALT);
  assign redirect_count = redirect_count_q;
  assign dbg_state      = state_q;
  assign dbg_pend_kind  = pend_kind_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Self-checking bench for pc_redirect_ctrl: directed vector table, hand-written
// multi-cycle sequences, randomized traffic against a behavioural model, and a
// counter saturation run.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;
  import pc_src_defs::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic          jal = 1'b0;
  logic [W-1:0]  jal_target = '0;
  logic          jalr = 1'b0;
  logic [W-1:0]  jalr_target = '0;
  logic          trap = 1'b0;
  logic [W-1:0]  trap_vector = '0;
  logic          halt_req = 1'b0;
  logic [2:0]    pc_src_sel;
  logic [W-1:0]  pend_target;
  logic          pc_write;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          halted;
  logic [15:0]   redirect_count;
  state_e        dbg_state;
  pc_sel_e       dbg_pend_kind;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  pc_redirect_ctrl #(.bit_with(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jal            (jal),
    .jal_target     (jal_target),
    .jalr           (jalr),
    .jalr_target    (jalr_target),
    .trap           (trap),
    .trap_vector    (trap_vector),
    .halt_req       (halt_req),
    .pc_src_sel     (pc_src_sel),
    .pend_target    (pend_target),
    .pc_write       (pc_write),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .halted         (halted),
    .redirect_count (redirect_count),
    .dbg_state      (dbg_state),
    .dbg_pend_kind  (dbg_pend_kind)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_comb(input string name, input logic [2:0] e_sel, input logic e_pw,
                            input logic e_fif, input logic e_fie, input logic e_halted);
    check({name, ".sel"}, 32'(pc_src_sel), 32'(e_sel));
    check({name, ".pc_write"}, 32'(pc_write), 32'(e_pw));
    check({name, ".flush_if_id"}, 32'(flush_if_id), 32'(e_fif));
    check({name, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e_fie));
    check({name, ".halted"}, 32'(halted), 32'(e_halted));
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    trap = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       stall, trap, jalr, br, jal;
    logic [2:0] e_sel;
    logic       e_pw, e_fif, e_fie;
  } vec_t;

  vec_t tbl[10];

  // ---------------- behavioural model state ----------------
  bit          m_pend, m_halt;
  logic [31:0] m_tgt;
  int          m_cnt;

  initial begin
    // stall trap jalr br jal | sel pw fif fie
    tbl[0] = '{0, 0, 0, 0, 0, 3'd0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 3'd0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 1, 0, 3'd1, 1, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 1, 3'd2, 1, 1, 0};
    tbl[4] = '{0, 0, 1, 0, 0, 3'd3, 1, 1, 1};
    tbl[5] = '{0, 1, 0, 0, 0, 3'd4, 1, 1, 1};
    tbl[6] = '{0, 0, 0, 1, 1, 3'd1, 1, 1, 1};
    tbl[7] = '{0, 0, 1, 1, 1, 3'd3, 1, 1, 1};
    tbl[8] = '{0, 1, 1, 1, 1, 3'd4, 1, 1, 1};
    tbl[9] = '{0, 0, 1, 0, 1, 3'd3, 1, 1, 1};

    // ---- reset state ----
    #2;
    check_comb("reset_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_held.count", 32'(redirect_count), 32'd0);
    check("reset_held.pend_target", pend_target, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_comb("idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle.count", 32'(redirect_count), 32'd0);

    // ---- table-driven RUN-state vectors ----
    begin
      int exp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (exp_q.size() > 0) check($sformatf("tbl%0d.count", i), 32'(redirect_count), exp_q.pop_front());
        stall = tbl[i].stall; trap = tbl[i].trap; jalr = tbl[i].jalr;
        branch_taken = tbl[i].br; jal = tbl[i].jal;
        branch_target = $urandom; jal_target = $urandom;
        jalr_target = $urandom; trap_vector = $urandom;
        #2;
        check_comb($sformatf("tbl%0d", i), tbl[i].e_sel, tbl[i].e_pw, tbl[i].e_fif, tbl[i].e_fie, 1'b0);
        if (tbl[i].e_fif) exp_cnt++;
        exp_q.push_back(32'(exp_cnt));
      end
      @(negedge clk);
      clear_inputs();
      check("tbl_end.count", 32'(redirect_count), exp_q.pop_front());
      check("tbl_end.pend_target", pend_target, 32'd0);
    end

    // ---- branch redirect, count next cycle ----
    do_reset();
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    #2;
    check_comb("branch", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    clear_inputs();
    #2;
    check("branch.count", 32'(redirect_count), 32'd1);

    // ---- stalled JALR: capture, hold 3 cycles, replay ----
    do_reset();
    stall = 1'b1; jalr = 1'b1; jalr_target = 32'h0000_0A40;
    #2;
    check_comb("jalr_st0", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    jalr = 1'b0; branch_taken = 1'b1; jal = 1'b1;  // ignored while pending
    #2;
    check_comb("jalr_st1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("jalr_st1.pend_target", pend_target, 32'h0000_0A40);
    @(negedge clk);
    branch_taken = 1'b0; jal = 1'b0;
    #2;
    check_comb("jalr_st2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    stall = 1'b0;
    #2;
    check_comb("jalr_release", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jalr_release.count", 32'(redirect_count), 32'd1);
    @(negedge clk);
    #2;
    check_comb("jalr_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- trap overwrites pending redirect while stalled ----
    do_reset();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    @(negedge clk);
    branch_taken = 1'b0; trap = 1'b1; trap_vector = 32'h0000_0004;
    #2;
    check_comb("pend_trap", 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pend_trap.old_target", pend_target, 32'h0000_0200);
    @(negedge clk);
    trap = 1'b0;
    #2;
    check("pend_trap.pend_target", pend_target, 32'h0000_0004);
    check("pend_trap.count", 32'(redirect_count), 32'd2);
    @(negedge clk);
    stall = 1'b0;
    #2;
    check_comb("pend_trap_release", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- trap arriving on the release cycle of a pending redirect ----
    do_reset();
    stall = 1'b1; jal = 1'b1; jal_target = 32'h0000_0300;
    #2;
    check_comb("jal_stalled", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    jal = 1'b0; stall = 1'b0; trap = 1'b1; trap_vector = 32'h0000_0008;
    #2;
    check_comb("pend_release_trap", 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    trap = 1'b0;
    #2;
    check("pend_release_trap.count", 32'(redirect_count), 32'd2);
    check_comb("pend_release_trap_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // ---- halt, ignored requests, asynchronous reset mid-cycle ----
    do_reset();
    halt_req = 1'b1;
    #2;
    check_comb("halt_req", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    halt_req = 1'b0; branch_taken = 1'b1; trap = 1'b1;
    #2;
    check_comb("halted", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    #2;
    check_comb("halted_late", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("halted_late.count", 32'(redirect_count), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_comb("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst.count", 32'(redirect_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // ---- randomized traffic against the behavioural model ----
    do_reset();
    m_pend = 0; m_halt = 0; m_tgt = '0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [2:0]  e_sel;
      logic        e_pw, e_fif, e_fie, accepted;
      int          w;
      logic [31:0] wt;
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        clear_inputs();
        branch_taken = 1'b1;
        #2;
        check_comb("rnd_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rnd_rst.count", 32'(redirect_count), 32'd0);
        check("rnd_rst.pend_target", pend_target, 32'd0);
        m_pend = 0; m_halt = 0; m_tgt = '0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      stall         = ($urandom_range(0, 2) == 0);
      trap          = ($urandom_range(0, 9) == 0);
      jalr          = ($urandom_range(0, 6) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      jal           = ($urandom_range(0, 4) == 0);
      halt_req      = ($urandom_range(0, 59) == 0);
      branch_target = $urandom; jal_target = $urandom;
      jalr_target   = $urandom; trap_vector = $urandom;

      // Winner by priority: 4 trap, 3 jalr, 1 branch, 2 jal, 9 halt, 0 none.
      w = 0; wt = '0;
      if (trap)              begin w = 4; wt = trap_vector;   end
      else if (jalr)         begin w = 3; wt = jalr_target;   end
      else if (branch_taken) begin w = 1; wt = branch_target; end
      else if (jal)          begin w = 2; wt = jal_target;    end
      else if (halt_req)     begin w = 9;                     end

      e_sel = 3'd0; e_pw = 1'b0; e_fif = 1'b0; e_fie = 1'b0; accepted = 1'b0;
      if (m_halt) begin
        // everything ignored
      end else if (m_pend) begin
        if (trap) begin
          e_fif = 1'b1; e_fie = 1'b1; accepted = 1'b1;
        end
        if (!stall) begin
          e_pw  = 1'b1;
          e_sel = trap ? 3'd4 : 3'd5;
        end
      end else if (w == 9) begin
        // halt: no flush, no write
      end else if (w != 0) begin
        accepted = 1'b1;
        e_fif = 1'b1;
        e_fie = (w != 2);
        if (!stall) begin
          e_sel = 3'(w);
          e_pw  = 1'b1;
        end
      end else begin
        e_pw = !stall;
      end

      #2;
      check_comb($sformatf("rnd%0d", cyc), e_sel, e_pw, e_fif, e_fie, m_halt);
      check($sformatf("rnd%0d.count", cyc), 32'(redirect_count), 32'(m_cnt));
      check($sformatf("rnd%0d.pend_target", cyc), pend_target, m_tgt);

      // Advance the model to what the next edge commits.
      if (accepted && m_cnt < 65535) m_cnt++;
      if (!m_halt) begin
        if (m_pend) begin
          if (trap && stall) m_tgt = trap_vector;
          if (!stall) m_pend = 0;
        end else if (w == 9) begin
          m_halt = 1;
        end else if (w != 0 && stall) begin
          m_pend = 1;
          m_tgt  = wt;
        end
      end
    end

    // ---- counter saturation ----
    do_reset();
    branch_taken = 1'b1;
    repeat (65535) @(negedge clk);
    #2;
    check("sat.count_max", 32'(redirect_count), 32'h0000_FFFF);
    check_comb("sat.still_redirecting", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    clear_inputs();
    #2;
    check("sat.count_hold", 32'(redirect_count), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Control block that drives the 3-bit select of the fetch-stage PC source mux. It arbitrates branch, JAL, JALR, trap and halt requests, and holds the PC while fetch is stalled. It also latches a redirect that arrives during a stall and replays it through mux input 5, and issues the pipeline flush pulses. It sits between the hazard unit, the ID/EX stages and the PC register.

## Interface
- bit_with, 32, width of PC and target buses
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  IF stall from hazard unit; PC must hold
- branch_taken  input  1  EX: conditional branch resolved taken
- branch_target  input  bit_with  EX branch target
- jal  input  1  ID: JAL decoded
- jal_target  input  bit_with  ID JAL target
- jalr  input  1  EX: JALR executing
- jalr_target  input  bit_with  EX JALR target
- trap  input  1  exception request (any stage, oldest)
- trap_vector  input  bit_with  trap handler address
- halt_req  input  1  ID: halt instruction decoded
- pc_src_sel  output  3  mux select: 0 PC+4, 1 branch, 2 JAL, 3 JALR, 4 trap, 5 pending target
- pend_target  output  bit_with  latched redirect target, wired to mux input 5
- pc_write  output  1  PC register load enable
- flush_if_id  output  1  one-cycle flush of IF/ID
- flush_id_ex  output  1  one-cycle flush of ID/EX
- halted  output  1  high in HALT
- redirect_count  output  16  accepted-redirect counter, saturating

## Operation
- Priority: trap > jalr > branch_taken > jal > halt_req. Only the winner is accepted; the others are discarded because they come from the wrong path.
- States: RUN, PEND, HALT. Reset enters RUN, with pend_target=0, pend_kind=0, redirect_count=0.
- RUN, winner present, stall=0:
  - pc_src_sel = winner code, pc_write=1, stay in RUN.
- RUN, winner present, stall=1:
  - pend_target <= winner target, pc_src_sel=0, pc_write=0, next state PEND.
- RUN, no winner:
  - pc_src_sel=0 and pc_write=~stall.
- RUN, halt_req is the winner:
  - No flush, pc_write=0, next state HALT. Stall does not matter.
- Flushes are issued in the cycle a redirect is accepted, whether or not stall is high:
  - trap, jalr or branch: flush_if_id=1 and flush_id_ex=1.
  - jal: flush_if_id=1 only.
- PEND, stall=1:
  - pc_write=0, pc_src_sel=0.
  - trap overwrites pend_target with trap_vector and flushes both stages.
  - All other requests are ignored.
- PEND, stall=0:
  - trap present: pc_src_sel=4, flush both, pc_write=1.
  - Otherwise: pc_src_sel=5, pc_write=1.
  - Next state RUN in both cases.
- HALT:
  - pc_write=0, pc_src_sel=0, no flushes, halted=1.
  - All requests are ignored. Only rst exits.
- redirect_count increments by 1 on each accepted redirect (flush cycle), including a trap that overwrites a pending redirect. It saturates at 0xFFFF.

## Timing
- pc_src_sel, pc_write and the flushes are combinational from inputs and current state, with the same-cycle path to the mux.
- pend_target, state and redirect_count are registered.
- pend_target is valid from the cycle after capture and is used no earlier than the first cycle stall=0.
- Latency from a redirect request to PC update:
  - 1 edge when not stalled.
  - When stalled, the first edge with stall=0.
- While rst=1 all outputs are 0, and registers clear asynchronously.
- Reset mid-PEND drops the pending target. The PC restarts from the reset vector, which is handled by the PC register.
- An unused select code (6, 7) is never produced.

## Structure
- A shared package/header `pc_src_defs` holds:
  - Select codes SEL_PC4=0, SEL_BR=1, SEL_JAL=2, SEL_JALR=3, SEL_TRAP=4, SEL_PEND=5.
  - State encodings RUN/PEND/HALT.
  - The counter width, 16.
- One sub-module, `redirect_prio_enc`: a combinational priority encoder from the request bits to a winner code, target select and flush mask.
- The FSM, pending register and counter live in the top level.

## Test plan
- Reset, then idle with stall=0 → pc_src_sel=0, pc_write=1, flushes=0, redirect_count=0.
- branch_taken=1 with branch_target=0x0000_0100, stall=0 → same cycle pc_src_sel=1, pc_write=1, both flushes=1; redirect_count=1 next cycle.
- jal=1 and branch_taken=1 together → pc_src_sel=1 and flush_id_ex=1; the JAL is dropped.
- Stall held 3 cycles with jalr=1 (jalr_target=0x0000_0A40) in the first cycle → pc_write=0 for 3 cycles, pend_target=0x0000_0A40; on release pc_src_sel=5, pc_write=1, then RUN.
- In PEND, trap=1 (trap_vector=0x0000_0004) while stalled → pend_target=0x0000_0004, both flushes, redirect_count+1; on release pc_src_sel=5 → PC=0x0000_0004.
- halt_req=1 → halted=1, pc_write=0 forever, later branch/trap ignored; rst=1 asserted asynchronously mid-cycle clears all outputs immediately.
